// File: rtl/half_band_interp_2.sv
// Half-band interpolate-by-2: even phase copies the delay-line centre tap, odd phase is a
// two-tap symmetric polyphase sum. Define HB_INTERP_SAT_EN to saturate the odd phase.
module half_band_interp_2 #(
    parameter logic signed [17:0] C1 = 18'sd78643,
    parameter logic signed [17:0] C3 = -18'sd13107
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [17:0] x_in,
    input  logic               x_valid,
    output logic               x_ready,
    output logic signed [17:0] y,
    output logic               y_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

    localparam logic signed [37:0] C1_X = {{20{C1[17]}}, C1};
    localparam logic signed [37:0] C3_X = {{20{C3[17]}}, C3};

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic signed [17:0] d0_r, d1_r, d2_r, d3_r;
    logic signed [18:0] s1_s, s3_s;
    logic signed [37:0] p_s, r_s;
    logic signed [17:0] odd_s;

    // Reduce the rounded product to the 18-bit output range.
    function automatic logic signed [17:0] reduce_odd(input logic signed [37:0] r);
`ifdef HB_INTERP_SAT_EN
        if (r > 38'sd131071) begin
            reduce_odd = 18'sd131071;
        end else if (r < -38'sd131072) begin
            reduce_odd = -18'sd131072;
        end else begin
            reduce_odd = r[17:0];
        end
`else
        reduce_odd = r[17:0];
`endif
    endfunction

    // Handshake and next-state decode.
    always_comb begin
        x_ready     = (state_r != PH0);
        accept_s    = x_valid && x_ready;
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = PH0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PH0: state_nxt_s = PH1;
            PH1: begin
                if (accept_s) begin
                    state_nxt_s = PH0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Odd-phase datapath from the current (pre-shift) delay line, round half up.
    always_comb begin
        s1_s  = {d1_r[17], d1_r} + {d2_r[17], d2_r};
        s3_s  = {d0_r[17], d0_r} + {d3_r[17], d3_r};
        p_s   = C1_X * {{19{s1_s[18]}}, s1_s} + C3_X * {{19{s3_s[18]}}, s3_s};
        r_s   = (p_s + 38'sd65536) >>> 5'd17;
        odd_s = reduce_odd(r_s);
    end

    // Phase state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Delay line shifts only on an accepted sample; history persists across idle gaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d0_r <= 18'sd0;
            d1_r <= 18'sd0;
            d2_r <= 18'sd0;
            d3_r <= 18'sd0;
        end else if (accept_s) begin
            d0_r <= x_in;
            d1_r <= d0_r;
            d2_r <= d1_r;
            d3_r <= d2_r;
        end else begin
            d0_r <= d0_r;
            d1_r <= d1_r;
            d2_r <= d2_r;
            d3_r <= d3_r;
        end
    end

    // Output register: even sample in PH0, odd sample in PH1, y holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y       <= 18'sd0;
            y_valid <= 1'b0;
        end else begin
            case (state_r)
                PH0: begin
                    y       <= d2_r;
                    y_valid <= 1'b1;
                end
                PH1: begin
                    y       <= odd_s;
                    y_valid <= 1'b1;
                end
                default: begin
                    y       <= y;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_band_interp_2.sv
// Scoreboard bench for half_band_interp_2: a history-array reference model pushes expected
// samples with their due cycle; an independent monitor pops and compares on y_valid.
module tb_half_band_interp_2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [17:0] x_in = 18'sd0;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic signed [17:0] y;
    logic               y_valid;

    half_band_interp_2 dut (
        .clk     (clk),
        .reset   (reset),
        .x_in    (x_in),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     cyc;
    } ent_t;

    localparam longint K1 = 78643;
    localparam longint K3 = -13107;
`ifdef HB_INTERP_SAT_EN
    localparam longint OVF_EXP = 131071;
`else
    localparam longint OVF_EXP = -78645;
`endif

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    ent_t   sb[$];
    ent_t   log_q[$];
    ent_t   mon_e;
    longint h[4];
    bit     exp_ready = 1'b1;
    longint imp_exp[8] = '{0, -6553, 0, 39322, 65536, 39322, 0, -6553};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Odd sample: midpoint of h[2]/h[1] by the symmetric two-tap half-band rule.
    function automatic longint odd_ref();
        longint p, r, w;
        p = K1 * (h[1] + h[2]) + K3 * (h[0] + h[3]);
        r = (p + 65536) >>> 17;
`ifdef HB_INTERP_SAT_EN
        if (r > 131071) r = 131071;
        if (r < -131072) r = -131072;
        return r;
`else
        w = r & 64'h3ffff;
        if (w >= 131072) w = w - 262144;
        return w;
`endif
    endfunction

    task automatic step(input bit v, input longint d);
        @(negedge clk);
        chk("x_ready", longint'(x_ready), longint'(exp_ready));
        x_valid = v;
        x_in    = 18'(d);
        @(posedge clk);
        #1;
        if (v && exp_ready) begin
            h[3] = h[2];
            h[2] = h[1];
            h[1] = h[0];
            h[0] = longint'(x_in);
            sb.push_back('{val: h[2], cyc: cyc + 1});
            sb.push_back('{val: odd_ref(), cyc: cyc + 2});
            exp_ready = 1'b0;
        end else begin
            exp_ready = 1'b1;
        end
    endtask

    // Monitor: every presented output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && y_valid) begin
            log_q.push_back('{val: longint'(y), cyc: cyc});
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual=%0d required=none", y);
            end else begin
                mon_e = sb.pop_front();
                chk("y_value", longint'(y), mon_e.val);
                chk("y_cycle", longint'(cyc), longint'(mon_e.cyc));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) h[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_y", longint'(y), 0);
        chk("rst_y_valid", longint'(y_valid), 0);
        chk("rst_x_ready", longint'(x_ready), 1);
        reset = 1'b1;

        repeat (10) step(1'b0, 0);
        chk("idle_outputs", longint'(log_q.size()), 0);

        // Impulse, with a rejected sample 5 offered during PH0.
        log_q.delete();
        step(1'b1, 65536);
        step(1'b1, 5);
        step(1'b1, 0);
        step(1'b0, 0);
        step(1'b1, 0);
        step(1'b0, 0);
        step(1'b1, 0);
        repeat (3) step(1'b0, 0);
        chk("imp_count", longint'(log_q.size()), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) chk("imp_val", log_q[i].val, imp_exp[i]);

        // DC with x_valid held high.
        log_q.delete();
        repeat (12) step(1'b1, 100000);
        repeat (3) step(1'b0, 0);
        chk("dc_count", longint'(log_q.size()), 12);
        for (int i = 6; i < log_q.size(); i++) chk("dc_val", log_q[i].val, 100000);
        for (int i = 1; i < log_q.size(); i++)
            chk("dc_continuous", longint'(log_q[i].cyc), longint'(log_q[0].cyc + i));

        // Overflow pattern.
        log_q.delete();
        step(1'b1, -131072); step(1'b0, 0);
        step(1'b1, 131071);  step(1'b0, 0);
        step(1'b1, 131071);  step(1'b0, 0);
        step(1'b1, -131072);
        repeat (3) step(1'b0, 0);
        chk("ovf_count", longint'(log_q.size()), 8);
        if (log_q.size() == 8) chk("ovf_odd", log_q[7].val, OVF_EXP);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), longint'($signed(18'($urandom))));
        end
        repeat (4) step(1'b0, 0);

        // Reset in PH0 drops the pending output and clears history.
        step(1'b1, 65536);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_y", longint'(y), 0);
        chk("mid_rst_y_valid", longint'(y_valid), 0);
        chk("mid_rst_x_ready", longint'(x_ready), 1);
        sb.delete();
        log_q.delete();
        for (int i = 0; i < 4; i++) h[i] = 0;
        exp_ready = 1'b1;
        x_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 0);
        repeat (3) step(1'b0, 0);
        chk("post_rst_count", longint'(log_q.size()), 2);
        for (int i = 0; i < log_q.size(); i++) chk("post_rst_val", log_q[i].val, 0);

        chk("sb_drained", longint'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/half_band_interp_2.md
# half_band_interp_2

Half-band interpolate-by-2 filter: the transmit-side counterpart of the half-band decimation stage. It accepts 18-bit signed samples at up to half the clock rate and emits two output samples per input: an even-phase pass-through sample and an odd-phase interpolated sample. It sits in the upsampling chain ahead of the DAC/modulator path, so the output rate can run at the full clock rate.

## Interface
- `C1`, default 78643: inner odd-phase coefficient, signed 18-bit Q1.17 (≈0.6).
- `C3`, default -13107: outer odd-phase coefficient, signed 18-bit Q1.17 (≈-0.1). `C1+C3` = 65536 (0.5) gives unity DC gain on both phases.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `x_in` input 18: signed input sample.
- `x_valid` input 1: `x_in` is valid this cycle.
- `x_ready` output 1: the block accepts `x_in` this cycle. The input is taken on the edge where `x_valid && x_ready`.
- `y` output 18: signed output sample, registered.
- `y_valid` output 1: `y` is valid this cycle. The output is one-cycle qualified; there is no output backpressure.

## Operation
- Delay line `d0..d3`, 18-bit signed, with `d0` newest. On accept: `d0<=x_in`, `d1<=d0`, `d2<=d1`, `d3<=d2`.
- FSM states:
  - IDLE:
    - accept → PH0.
  - PH0:
    - `y<=d2`, `y_valid<=1`.
    - Always → PH1.
    - `x_ready=0`.
  - PH1:
    - `y<=odd`, `y_valid<=1`.
    - Accept in the same cycle → PH0; otherwise → IDLE.
- `x_ready` = (state != PH0). It is combinational from the state.
- In any cycle where no output is written, `y_valid<=0`. `y` holds its last value.
- Odd-phase arithmetic (two-tap symmetric polyphase):
  - `s1 = d1+d2`, `s3 = d0+d3`, both 19-bit signed with no overflow.
  - `P = C1*s1 + C3*s3`, 38-bit signed, full precision.
  - `R = (P + 2^16) >>> 17`: round half up, arithmetic shift.
  - `odd` = R reduced to 18 bits (see Configuration).
- The PH1 computation uses the delay line values from before any same-edge accept shift.
- The even phase is an exact copy of `d2`. No arithmetic is applied and it cannot overflow.
- Output ordering per accepted sample: the even sample (`d2`) first, then the odd sample. The odd sample is interpolated midway between `d2` and `d1`.

## Timing
- Reset (asynchronous assert, any time):
  - state = IDLE, `d0..d3` = 0, `y` = 0, `y_valid` = 0.
  - `x_ready` = 1 during and after reset.
- Reset mid-operation: a pending even or odd output is dropped. The next output appears only after a new accept, computed against zero history.
- Latency, for an accept on edge E:
  - The even output is registered at E+1, so `y_valid` is high in the cycle after E+1.
  - The odd output is registered at E+2.
- Throughput: at most one input per 2 clocks.
  - With `x_valid` held high, accepts occur on alternate edges.
  - `x_ready` toggles 1,0,1,0,…
  - `y_valid` stays continuously high after the first output.
- `x_valid` while `x_ready=0` is ignored. The source must hold the sample; it is not latched.
- Idle gaps: `y_valid` drops to 0 one cycle after the PH1 output. The delay line retains its history across gaps and does not flush.

## Configuration
- `HB_INTERP_SAT_EN`:
  - Defined: `odd` saturates. R > 131071 → 131071; R < -131072 → -131072.
  - Undefined: `odd` = R[17:0], two's-complement wrap with no saturation logic.

## Test plan
- Reset release, idle: `y`=0, `y_valid`=0, `x_ready`=1. No output for 10 cycles with `x_valid`=0.
- Impulse: accept 65536, then 0, 0, 0 at one input per 2 clocks → `y` sequence 0, -6553, 0, 39322, 65536, 39322, 0, -6553.
- DC: continuous 100000 with `x_valid` held high → after the 4th accept, every output is 100000. `x_ready` alternates and `y_valid` is continuously 1.
- Overflow: accept -131072, 131071, 131071, -131072. The 4th odd output is 131071 with `HB_INTERP_SAT_EN`, or -78645 without it.
- Backpressure: pulse `x_valid` with value 5 during PH0 (`x_ready`=0) only → not accepted, the delay line is unchanged, and no extra outputs appear.
- Reset mid-operation: assert `reset` in PH0 after accepting 65536 → `y_valid` drops immediately and `y`=0. After release, accepting 0 gives outputs 0, 0; the history has been cleared.
